// File: rtl/axil_block_sequencer.sv
// AXI4-Lite master that loads N_WORDS words into a slave, starts it, polls for
// completion, and streams the results back out as a valid-only stream.
module axil_block_sequencer #(
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            C_M_AXI_ADDR_WIDTH = 8,
  parameter int                            N_WORDS            = 16,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] WR_BASE            = 8'h00,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] RD_BASE            = 8'h40,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] CFG_START          = 8'h80,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] CFG_DONE           = 8'h89
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic                          start,
  output logic                          done,
  output logic                          err,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] in_tdata,
  input  logic                          in_tvalid,
  output logic                          in_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] out_tdata,
  output logic                          out_tvalid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int            CW   = $clog2(N_WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR_REQ, S_WR_RESP, S_CFG_WR,
    S_POLL_REQ, S_POLL_RESP, S_RD_REQ, S_RD_RESP, S_FIN
  } state_t;

  state_t                        state, state_next;
  logic [CW-1:0]                 cnt;
  logic                          aw_done, w_done;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;

  logic aw_hs, w_hs, b_hs, r_hs;
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
  assign r_hs  = M_AXI_RVALID  && M_AXI_RREADY;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      wdata_q    <= '0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      out_tvalid <= 1'b0;
      // AW and W may complete in different cycles; remember each until the beat moves on
      if (state != state_next) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (state == S_FETCH && in_tvalid) wdata_q <= in_tdata;
      if (state == S_IDLE && start) begin
        cnt <= '0;
        err <= 1'b0;
      end else if (state == S_POLL_RESP && M_AXI_RVALID && M_AXI_RDATA[0]) begin
        cnt <= '0;
      end else if ((state == S_WR_RESP && M_AXI_BVALID) || (state == S_RD_RESP && M_AXI_RVALID)) begin
        cnt <= cnt + 1'b1;
      end
      if (state == S_RD_RESP && M_AXI_RVALID) begin
        out_tdata  <= M_AXI_RDATA;
        out_tvalid <= 1'b1;
      end
      if ((b_hs && M_AXI_BRESP != 2'b00) || (r_hs && M_AXI_RRESP != 2'b00)) err <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (start) state_next = S_FETCH;
      S_FETCH:     if (in_tvalid) state_next = S_WR_REQ;
      S_WR_REQ:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = S_WR_RESP;
      S_WR_RESP:   if (M_AXI_BVALID) state_next = (cnt == LAST) ? S_CFG_WR : S_FETCH;
      S_CFG_WR:    if (b_hs) state_next = S_POLL_REQ;
      S_POLL_REQ:  if (M_AXI_ARREADY) state_next = S_POLL_RESP;
      S_POLL_RESP: if (M_AXI_RVALID) state_next = M_AXI_RDATA[0] ? S_RD_REQ : S_POLL_REQ;
      S_RD_REQ:    if (M_AXI_ARREADY) state_next = S_RD_RESP;
      S_RD_RESP:   if (M_AXI_RVALID) state_next = (cnt == LAST) ? S_FIN : S_RD_REQ;
      S_FIN:       state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_tready     = 1'b0;
    done          = 1'b0;
    M_AXI_AWADDR  = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state)
      S_FETCH: in_tready = 1'b1;
      S_WR_REQ: begin
        M_AXI_AWADDR  = WR_BASE + C_M_AXI_ADDR_WIDTH'(cnt);
        M_AXI_AWVALID = !aw_done;
        M_AXI_WDATA   = wdata_q;
        M_AXI_WVALID  = !w_done;
      end
      S_WR_RESP: M_AXI_BREADY = 1'b1;
      // Config write runs its address, data and response phases in one state
      S_CFG_WR: begin
        M_AXI_AWADDR  = CFG_START;
        M_AXI_AWVALID = !aw_done;
        M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(1);
        M_AXI_WVALID  = !w_done;
        M_AXI_BREADY  = aw_done && w_done;
      end
      S_POLL_REQ: begin
        M_AXI_ARADDR  = CFG_DONE;
        M_AXI_ARVALID = 1'b1;
      end
      S_POLL_RESP: M_AXI_RREADY = 1'b1;
      S_RD_REQ: begin
        M_AXI_ARADDR  = RD_BASE + C_M_AXI_ADDR_WIDTH'(cnt);
        M_AXI_ARVALID = 1'b1;
      end
      S_RD_RESP: M_AXI_RREADY = 1'b1;
      S_FIN:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_block_sequencer.sv
// Directed bench: behavioural AXI-Lite slave with programmable ready latency,
// poll count and error injection, plus a handshake-hold monitor.
module tb_axil_block_sequencer;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, done, err;
  logic [DW-1:0] in_tdata;
  logic          in_tvalid, in_tready;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready;
  logic [DW-1:0] wdata, rdata;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  axil_block_sequencer #(.N_WORDS(NW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start), .done(done), .err(err),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // ---------------- slave model ----------------
  int aw_lat = 0, w_lat = 0, bad_b = -1, poll_zeros = 0;
  int aw_wait, w_wait, b_count = 0, poll_idx = 0, viol = 0;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d;
  logic [AW-1:0] aw_log_a[$];
  logic [DW-1:0] aw_log_d[$];
  logic [AW-1:0] ar_log[$];
  logic [DW-1:0] out_log[$];

  assign awready = awvalid && !aw_got && (aw_wait >= aw_lat);
  assign wready  = wvalid  && !w_got  && (w_wait  >= w_lat);
  assign arready = arvalid && !rvalid;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (awvalid && awready) begin aw_got <= 1'b1; aw_a <= awaddr; end
      if (wvalid && wready)   begin w_got  <= 1'b1; w_d  <= wdata;  end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        aw_log_a.push_back(aw_got ? aw_a : awaddr);
        aw_log_d.push_back(w_got ? w_d : wdata);
        if ((aw_got ? aw_a : awaddr) == 8'h80) poll_idx <= 0;
        bvalid <= 1'b1;
        bresp  <= (b_count == bad_b) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; b_count <= b_count + 1; end
      if (arvalid && arready) begin
        ar_log.push_back(araddr);
        rvalid <= 1'b1;
        rresp  <= 2'b00;
        if (araddr == 8'h89) begin
          rdata    <= (poll_idx >= poll_zeros) ? 32'd1 : 32'd0;
          poll_idx <= poll_idx + 1;
        end else begin
          rdata <= 32'hC0DE_0000 | {24'h0, araddr};
        end
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (out_tvalid) out_log.push_back(out_tdata);
    end
  end

  // VALIDs must hold with stable payload until their own READY; AR never with AW/W
  logic          p_aw, p_w, p_ar;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  always @(posedge clk) begin
    if (rst) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
    end else begin
      if (p_aw && (!awvalid || awaddr != p_awaddr)) viol <= viol + 1;
      if (p_w && (!wvalid || wdata != p_wdata))     viol <= viol + 1;
      if (p_ar && (!arvalid || araddr != p_araddr)) viol <= viol + 1;
      if (arvalid && (awvalid || wvalid))           viol <= viol + 1;
      p_aw <= awvalid && !awready; p_awaddr <= awaddr;
      p_w  <= wvalid && !wready;   p_wdata  <= wdata;
      p_ar <= arvalid && !arready; p_araddr <= araddr;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input string tn, input logic [DW-1:0] words[NW], input int pz,
                         input int gap_at, input bit fin_start, input bit exp_err);
    int ab, rb, ob, bb, na;
    bit found;
    ab = aw_log_a.size(); rb = ar_log.size(); ob = out_log.size(); bb = b_count;
    poll_zeros = pz;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tn, "_err_clr"}, err, 0);
    for (int i = 0; i < NW; i++) begin
      in_tdata = words[i]; in_tvalid = 1'b1; found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
        if (in_tready) found = 1; else @(negedge clk);
      end
      if (!found) check({tn, "_feed_timeout"}, 1, 0);
      @(negedge clk);
      in_tvalid = 1'b0;
      if (i == gap_at) begin
        start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        na = aw_log_a.size();
        check({tn, "_gap_aw_count"}, na - ab, i + 1);
        check({tn, "_gap_awvalid"}, awvalid, 0);
      end
    end
    found = 0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    check({tn, "_done_seen"}, found, 1);
    check({tn, "_err_at_done"}, err, exp_err);
    if (fin_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tn, "_done_width"}, done, 0);
    if (fin_start) begin
      @(negedge clk);
      check({tn, "_fin_start_ignored"}, in_tready, 0);
    end
    check({tn, "_aw_count"}, aw_log_a.size() - ab, NW + 1);
    for (int i = 0; i < NW; i++) begin
      check($sformatf("%s_awaddr%0d", tn, i), aw_log_a[ab + i], i);
      check($sformatf("%s_wdata%0d", tn, i), aw_log_d[ab + i], words[i]);
    end
    check({tn, "_cfg_addr"}, aw_log_a[ab + NW], 8'h80);
    check({tn, "_cfg_data"}, aw_log_d[ab + NW], 1);
    check({tn, "_b_count"}, b_count - bb, NW + 1);
    check({tn, "_ar_count"}, ar_log.size() - rb, pz + 1 + NW);
    for (int i = 0; i <= pz; i++)
      check($sformatf("%s_poll%0d", tn, i), ar_log[rb + i], 8'h89);
    for (int i = 0; i < NW; i++)
      check($sformatf("%s_araddr%0d", tn, i), ar_log[rb + pz + 1 + i], 8'h40 + i);
    check({tn, "_out_count"}, out_log.size() - ob, NW);
    for (int i = 0; i < NW && ob + i < out_log.size(); i++)
      check($sformatf("%s_out%0d", tn, i), out_log[ob + i], 32'hC0DE_0040 + i);
    check({tn, "_protocol"}, viol, 0);
  endtask

  logic [DW-1:0] wa[NW];
  logic [DW-1:0] wb[NW];
  bit found;

  initial begin
    rst = 1'b1; start = 1'b0; in_tvalid = 1'b0; in_tdata = '0;
    wa = '{32'd11, 32'd22, 32'd33, 32'd44};
    wb = '{32'hDEAD_0001, 32'h0000_FFFF, 32'h8000_0000, 32'h1234_5678};
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {done, err, in_tready, out_tvalid, awvalid, wvalid, bready, arvalid, rready}, 0);
    check("reset_buses", {out_tdata, awaddr, araddr, wdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_job("t1", wa, 0, -1, 1'b0, 1'b0);
    run_job("t2", wb, 3, -1, 1'b1, 1'b0);
    aw_lat = 3; w_lat = 0;
    run_job("t3a", wa, 1, -1, 1'b0, 1'b0);
    aw_lat = 0; w_lat = 3;
    run_job("t3b", wb, 0, -1, 1'b0, 1'b0);
    w_lat = 0;
    bad_b = b_count + 2;
    run_job("t4", wa, 0, -1, 1'b0, 1'b1);
    bad_b = -1;
    run_job("t5", wb, 2, 1, 1'b0, 1'b0);

    // reset while polling forever
    poll_zeros = 1000000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      in_tdata = wa[i]; in_tvalid = 1'b1; found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
        if (in_tready) found = 1; else @(negedge clk);
      end
      @(negedge clk);
      in_tvalid = 1'b0;
    end
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      if (arvalid && araddr == 8'h89) found = 1;
    end
    check("t6_poll_reached", found, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_reset_outputs",
          {done, err, in_tready, out_tvalid, awvalid, wvalid, bready, arvalid, rready}, 0);
    check("t6_reset_buses", {out_tdata, awaddr, araddr, wdata}, 0);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_idle_after_reset", in_tready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_job("t7", wa, 1, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
